// File: rtl/mux_pkg.sv
// Shared definitions for the channel mux: mode encodings, output FSM states, width helper.
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FULL   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_ptr.sv
// Scan channel pointer wrapping at NCH-1; advances by one on adv, clr/rst force it to 0.
// Pointer is registered; clr has priority over adv.
module mux_scan_ptr
  import mux_pkg::*;
#(
  parameter int NCH = 8,
  localparam int SW = (clog2(NCH) < 1) ? 1 : clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [SW-1:0] ptr,
  output logic          last
);

  logic [SW-1:0] r_ptr;

  assign last = (r_ptr == SW'(NCH - 1));
  assign ptr  = r_ptr;

  // Explicit compare-and-wrap so non-power-of-2 NCH never visits unused codes.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_ptr <= '0;
    end else if (adv) begin
      r_ptr <= last ? '0 : r_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan_n.sv
// N-channel mux with registered output and valid/ready handshake; 1-cycle load-to-output latency.
// Sample is held while VLD=1 and RDY=0; a transfer and a load in the same cycle stream back-to-back.
module mux_scan_n
  import mux_pkg::*;
#(
  parameter int NCH = 8,
  parameter int W   = 1,
  localparam int SW = (clog2(NCH) < 1) ? 1 : clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH*W-1:0] I,
  input  logic [SW-1:0]    S,
  input  logic             EN,
  input  logic             MODE,
  input  logic             RDY,
  output logic [W-1:0]     Y,
  output logic [SW-1:0]    Y_CH,
  output logic             VLD,
  output logic             WRAP
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_y;
  logic [SW-1:0] r_ych;
  logic          r_wrap;

  logic          w_scan;
  logic          w_ld;
  logic          w_xfer;
  logic          w_last;
  logic [SW-1:0] w_ptr;
  logic [SW-1:0] w_ch;
  logic [W-1:0]  w_dat;

  assign w_scan = (MODE == MODE_SCAN);
  assign VLD    = (r_state != ST_IDLE);
  assign w_xfer = VLD & RDY;
  assign w_ld   = EN & (~VLD | RDY);
  assign w_ch   = w_scan ? w_ptr : S;

  mux_scan_ptr #(
    .NCH (NCH)
  ) u_ptr (
    .clk  (clk),
    .rst  (rst),
    .clr  (~w_scan),
    .adv  (w_ld & w_scan),
    .ptr  (w_ptr),
    .last (w_last)
  );

  // Out-of-range selects match no channel and yield zero data.
  always_comb begin
    w_dat = '0;
    for (int k = 0; k < NCH; k++) begin
      if (w_ch == SW'(k)) w_dat = I[k*W +: W];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_ld) w_state_nxt = ST_FULL;
      end
      ST_FULL, ST_STREAM: begin
        if (w_xfer) w_state_nxt = w_ld ? ST_STREAM : ST_IDLE;
        else        w_state_nxt = ST_FULL;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // WRAP travels with the sample: held while stalled, dropped once the sample is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y    <= '0;
      r_ych  <= '0;
      r_wrap <= 1'b0;
    end else if (w_ld) begin
      r_y    <= w_dat;
      r_ych  <= w_ch;
      r_wrap <= w_scan & w_last;
    end else if (w_xfer) begin
      r_wrap <= 1'b0;
    end
  end

  assign Y    = r_y;
  assign Y_CH = r_ych;
  assign WRAP = r_wrap;

endmodule
